fft_frame_sched: RTL and testbench
==================================

# fft_frame_sched

Frame scheduler that time-shares a single streaming FFT instance between NUM_CH receive channels in the RX Ethernet datapath. It arbitrates round-robin on whole OFDM symbols, strips the cyclic prefix, and drives the FFT sink with correct sop/eop framing and a per-channel direction bit. It tags every FFT output frame with the channel that produced it, so downstream packers can demultiplex the shared FFT output.

## Interface
Parameters:
- NUM_CH, 2, number of requesting channels (2..8)
- CH_WIDTH, 1, width of channel id; equals ceil(log2(NUM_CH)), minimum 1
- FFT_SIZE, 1024, samples per FFT frame
- INDX_WIDTH, 10, sample index width; equals log2(FFT_SIZE)
- DATA_WIDTH, 16, width of the real and imag sample components
- CP_WIDTH, 10, width of cyclic-prefix length
- TAG_DEPTH, 4, depth of the in-flight channel tag FIFO (power of 2)

Ports:
- clk  in  1  clock, posedge active
- rst  in  1  reset, synchronous, active-high
- cp_len  in  CP_WIDTH  CP samples discarded before each frame; sampled at grant
- inverse_cfg  in  NUM_CH  per-channel direction, '0' = FFT, '1' = IFFT; sampled at grant
- ch_req  in  NUM_CH  channel has a full symbol (CP + FFT_SIZE) available
- ch_valid  in  NUM_CH  per-channel sample valid
- ch_real  in  NUM_CH*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- ch_imag  in  NUM_CH*DATA_WIDTH  same packing as ch_real
- ch_ready  out  NUM_CH  per-channel sample accept
- fft_sink_ready  in  1  from FFT
- fft_sink_valid, fft_sink_sop, fft_sink_eop  out  1  to FFT
- fft_sink_real, fft_sink_imag  out  DATA_WIDTH  to FFT
- fft_inverse  out  1  to FFT
- fft_source_valid, fft_source_sop, fft_source_eop, dout_ready  in  1  FFT output handshake, observed only
- dout_ch  out  CH_WIDTH  channel id of the current output frame (tag FIFO head)
- busy  out  1  state is not ARB
- tag_err  out  1  sticky error flag

## Operation
- State machine states:
  - ARB: if any ch_req is set and the tag FIFO is not full, latch grant g, cp_len and inverse_cfg[g].
    - If cp_len != 0, go to SKIP; otherwise go to DATA.
    - If no eligible request, stay in ARB.
  - SKIP: ch_ready[g] = 1; each cycle with ch_valid[g] decrements the CP counter; samples are discarded.
    - When the counter reaches 0, go to DATA.
  - DATA:
    - ch_ready[g] = fft_sink_ready.
    - fft_sink_valid = ch_valid[g] & fft_sink_ready; data is muxed combinationally from channel g.
    - The index counter advances on each accepted sample.
    - sop = valid & index==0; eop = valid & index==FFT_SIZE-1.
    - On eop: push g into the tag FIFO, reset the index to 0, go to ARB.
- Round-robin arbitration:
  - Search starts at (last grant + 1) mod NUM_CH.
  - After reset, the search starts at channel 0.
- ch_ready of every non-granted channel is 0 in all states.
- fft_inverse holds the latched value from grant through the end of DATA, covering sop.
- Tag FIFO:
  - Pop when fft_source_valid & fft_source_eop & dout_ready.
  - dout_ch = head entry; it is 0 when the FIFO is empty.
  - A push and a pop in the same cycle leave the occupancy unchanged.
- tag_err is set when fft_source_valid & fft_source_sop occurs while the FIFO is empty. It clears only on rst.
- ch_req is examined only in ARB; deasserting it mid-frame does not abort the frame.

## Timing
- Reset values:
  - State = ARB; all ch_ready = 0.
  - fft_sink_valid/sop/eop = 0; fft_sink_real/imag = 0; fft_inverse = 0.
  - dout_ch = 0; busy = 0; tag_err = 0.
  - FIFO empty; round-robin pointer at 0.
- Grant latency: request seen in ARB at cycle n -> state SKIP/DATA and ch_ready[g] at cycle n+1.
- No added latency from ch_* to fft_sink_*; the data path is combinational through the mux.
- Inter-frame gap: eop at cycle n -> earliest next sop at n+2 (n+1 ARB, n+2 DATA with cp_len=0).
- Back-pressure: fft_sink_ready low stalls the index; no sample is lost or duplicated.
- The cp_len value is frozen for the frame. A cp_len change during SKIP/DATA affects only the next grant.
- rst mid-frame: return to ARB, flush FIFO, clear the index. The FFT IP must be reset in the same cycle by the integrator.

## Test plan
- Single channel, NUM_CH=2, cp_len=72, ch_req[0] held, continuous valid:
  - 72 samples consumed with fft_sink_valid=0, then 1024 forwarded.
  - sop at sample index 0, eop at index 1023; dout_ch=0 on the output frame.
- Both channels requesting continuously, cp_len=0:
  - Grants alternate 0,1,0,1.
  - Eop-to-sop gap is exactly 1 idle cycle; dout_ch follows 0,1,0,1 on output frames.
- Random fft_sink_ready (50%) and ch_valid gaps:
  - The FFT receives an exact in-order copy of channel samples.
  - The index never exceeds 1023; eop occurs only on accepted sample 1023.
- TAG_DEPTH=4 with dout_ready=0:
  - After 4 frames, no further grant and busy=0 despite requests.
  - Raising dout_ready pops one tag per output eop and scheduling resumes.
- inverse_cfg=2'b10:
  - fft_inverse=0 throughout channel 0 frames and 1 throughout channel 1 frames.
  - A mid-frame change of inverse_cfg has no effect.
- rst asserted at sample 500 of a frame:
  - All outputs at reset values next cycle; the FIFO is empty.
  - The next frame starts with sop at index 0 from channel 0.
  - A forced fft_source_sop with an empty FIFO sets tag_err, and it stays set until rst.

Source files
------------

// File: rtl/fft_frame_sched.sv
// fft_frame_sched
//   Time-shares one streaming FFT between NUM_CH receive channels. Whole OFDM
//   symbols are granted round-robin; the cyclic prefix is dropped and the
//   remaining FFT_SIZE samples are forwarded with sop/eop framing and the
//   channel's direction bit. Each forwarded frame pushes its channel id into
//   a small tag FIFO. The FIFO head labels the matching FFT output frame, so
//   downstream logic can tell which channel an output frame belongs to.
//
// Ports
//   clk, rst            clock (posedge) and synchronous active-high reset
//   cp_len, inverse_cfg per-grant configuration, sampled when a grant is made
//   ch_req/valid/real/imag, ch_ready   channel-side sample stream
//   fft_sink_*, fft_inverse            FFT input stream
//   fft_source_*, dout_ready           FFT output handshake (observed only)
//   dout_ch             channel id of the current FFT output frame
//   busy                high whenever a symbol is being skipped or forwarded
//   tag_err             sticky: FFT output frame started with no tag queued
//
// state | meaning
// ------+--------------------------------------------------------------
// ARB   | idle; pick the next requesting channel if a tag slot is free
// SKIP  | discard cp_len valid samples of the granted channel
// DATA  | forward FFT_SIZE samples of the granted channel to the FFT

module fft_frame_sched #(
  parameter int NUM_CH     = 2,
  parameter int CH_WIDTH   = 1,
  parameter int FFT_SIZE   = 1024,
  parameter int INDX_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int CP_WIDTH   = 10,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CP_WIDTH-1:0]          cp_len,
  input  logic [NUM_CH-1:0]            inverse_cfg,
  input  logic [NUM_CH-1:0]            ch_req,
  input  logic [NUM_CH-1:0]            ch_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_real,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_imag,
  output logic [NUM_CH-1:0]            ch_ready,
  input  logic                         fft_sink_ready,
  output logic                         fft_sink_valid,
  output logic                         fft_sink_sop,
  output logic                         fft_sink_eop,
  output logic [DATA_WIDTH-1:0]        fft_sink_real,
  output logic [DATA_WIDTH-1:0]        fft_sink_imag,
  output logic                         fft_inverse,
  input  logic                         fft_source_valid,
  input  logic                         fft_source_sop,
  input  logic                         fft_source_eop,
  input  logic                         dout_ready,
  output logic [CH_WIDTH-1:0]          dout_ch,
  output logic                         busy,
  output logic                         tag_err
);

  localparam logic [1:0] ST_ARB  = 2'd0;
  localparam logic [1:0] ST_SKIP = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  // TAG_DEPTH is a power of two (>= 2), so the pointers wrap naturally.
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = $clog2(TAG_DEPTH + 1);

  logic [1:0]            state_q, state_d;
  logic [CH_WIDTH-1:0]   grant_q, grant_d;
  logic [CH_WIDTH-1:0]   rr_q, rr_d;
  logic [CP_WIDTH-1:0]   cp_cnt_q, cp_cnt_d;
  logic                  inv_q, inv_d;
  logic [INDX_WIDTH-1:0] idx_q, idx_d;
  logic [CH_WIDTH-1:0]   tag_mem_q [TAG_DEPTH];
  logic [CH_WIDTH-1:0]   tag_mem_d [TAG_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  tag_err_q, tag_err_d;

  logic                  req_found;
  logic [CH_WIDTH-1:0]   req_sel;
  logic [CH_WIDTH-1:0]   cand;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  in_data;
  logic                  push;
  logic                  pop;

  assign fifo_full  = (count_q == CNT_W'(TAG_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign in_data    = (state_q == ST_DATA);

  // Round-robin search from rr_q. Scanning offsets from high to low and
  // overwriting leaves the closest requester (smallest offset) selected.
  always_comb begin
    req_found = 1'b0;
    req_sel   = '0;
    cand      = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand = CH_WIDTH'((int'(rr_q) + k) % NUM_CH);
      if (ch_req[cand]) begin
        req_found = 1'b1;
        req_sel   = cand;
      end
    end
  end

  // Sample path is purely combinational from the granted channel.
  always_comb begin
    fft_sink_valid = in_data & ch_valid[grant_q] & fft_sink_ready;
    fft_sink_sop   = fft_sink_valid & (idx_q == '0);
    fft_sink_eop   = fft_sink_valid & (idx_q == INDX_WIDTH'(FFT_SIZE - 1));
    fft_sink_real  = '0;
    fft_sink_imag  = '0;
    if (in_data) begin
      fft_sink_real = ch_real[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
      fft_sink_imag = ch_imag[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    end
    ch_ready = '0;
    if (state_q == ST_SKIP) ch_ready[grant_q] = 1'b1;
    else if (in_data)       ch_ready[grant_q] = fft_sink_ready;
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    cp_cnt_d = cp_cnt_q;
    inv_d    = inv_q;
    idx_d    = idx_q;
    case (state_q)
      ST_ARB: begin
        if (req_found && !fifo_full) begin
          grant_d  = req_sel;
          rr_d     = CH_WIDTH'((int'(req_sel) + 1) % NUM_CH);
          cp_cnt_d = cp_len;
          inv_d    = inverse_cfg[req_sel];
          idx_d    = '0;
          state_d  = (cp_len != '0) ? ST_SKIP : ST_DATA;
        end
      end
      ST_SKIP: begin
        if (ch_valid[grant_q]) begin
          cp_cnt_d = cp_cnt_q - CP_WIDTH'(1);
          if (cp_cnt_q == CP_WIDTH'(1)) state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (fft_sink_valid) begin
          if (fft_sink_eop) begin
            idx_d   = '0;
            state_d = ST_ARB;
          end else begin
            idx_d = idx_q + INDX_WIDTH'(1);
          end
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  // Tag FIFO. A push can never hit a full FIFO: grants are withheld while
  // it is full and only one frame is in the scheduler at a time.
  assign push = fft_sink_eop;
  assign pop  = fft_source_valid & fft_source_eop & dout_ready & ~fifo_empty;

  always_comb begin
    tag_mem_d = tag_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push) begin
      tag_mem_d[wr_ptr_q] = grant_q;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    tag_err_d = tag_err_q | (fft_source_valid & fft_source_sop & fifo_empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ARB;
      grant_q   <= '0;
      rr_q      <= '0;
      cp_cnt_q  <= '0;
      inv_q     <= 1'b0;
      idx_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tag_err_q <= 1'b0;
      for (int i = 0; i < TAG_DEPTH; i++) tag_mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      cp_cnt_q  <= cp_cnt_d;
      inv_q     <= inv_d;
      idx_q     <= idx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      tag_err_q <= tag_err_d;
      tag_mem_q <= tag_mem_d;
    end
  end

  assign fft_inverse = inv_q;
  assign dout_ch     = fifo_empty ? '0 : tag_mem_q[rd_ptr_q];
  assign busy        = (state_q != ST_ARB);
  assign tag_err     = tag_err_q;

endmodule

// File: tb/tb_fft_frame_sched.sv
module tb_fft_frame_sched;

  localparam int NUM_CH = 2;
  localparam int CHW    = 1;
  localparam int FFT    = 1024;
  localparam int IW     = 10;
  localparam int DW     = 16;
  localparam int CPW    = 10;
  localparam int TD     = 4;

  logic                 clk;
  logic                 rst;
  logic [CPW-1:0]       cp_len;
  logic [NUM_CH-1:0]    inverse_cfg;
  logic [NUM_CH-1:0]    ch_req;
  logic [NUM_CH-1:0]    ch_valid;
  logic [NUM_CH*DW-1:0] ch_real;
  logic [NUM_CH*DW-1:0] ch_imag;
  logic [NUM_CH-1:0]    ch_ready;
  logic                 fft_sink_ready;
  logic                 fft_sink_valid, fft_sink_sop, fft_sink_eop;
  logic [DW-1:0]        fft_sink_real, fft_sink_imag;
  logic                 fft_inverse;
  logic                 fft_source_valid, fft_source_sop, fft_source_eop, dout_ready;
  logic [CHW-1:0]       dout_ch;
  logic                 busy, tag_err;

  fft_frame_sched #(
    .NUM_CH(NUM_CH), .CH_WIDTH(CHW), .FFT_SIZE(FFT), .INDX_WIDTH(IW),
    .DATA_WIDTH(DW), .CP_WIDTH(CPW), .TAG_DEPTH(TD)
  ) dut (
    .clk(clk), .rst(rst), .cp_len(cp_len), .inverse_cfg(inverse_cfg),
    .ch_req(ch_req), .ch_valid(ch_valid), .ch_real(ch_real), .ch_imag(ch_imag),
    .ch_ready(ch_ready), .fft_sink_ready(fft_sink_ready),
    .fft_sink_valid(fft_sink_valid), .fft_sink_sop(fft_sink_sop),
    .fft_sink_eop(fft_sink_eop), .fft_sink_real(fft_sink_real),
    .fft_sink_imag(fft_sink_imag), .fft_inverse(fft_inverse),
    .fft_source_valid(fft_source_valid), .fft_source_sop(fft_source_sop),
    .fft_source_eop(fft_source_eop), .dout_ready(dout_ready),
    .dout_ch(dout_ch), .busy(busy), .tag_err(tag_err)
  );

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          sop;
    logic          eop;
    logic          inv;
  } smp_t;

  smp_t sb_q[$];
  int   tag_q[$];
  int   pos_exp [NUM_CH];
  int   src_pos [NUM_CH];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   last_eop = -1;
  bit   gap_chk = 0;
  bit   rnd_mode = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached, got %0d cycles, want completion", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] f_re(input int c, input int p);
    logic [31:0] cv, pv;
    cv = c;
    pv = p;
    return {cv[2:0], pv[12:0]};
  endfunction

  function automatic logic [DW-1:0] f_im(input int c, input int p);
    return DW'(p * 3 + c * 4369);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected frame: cp samples of channel c are skipped, then n samples go to the FFT.
  task automatic push_frame(input int c, input int cp, input bit inv, input int n);
    smp_t e;
    pos_exp[c] += cp;
    for (int i = 0; i < n; i++) begin
      e.re  = f_re(c, pos_exp[c]);
      e.im  = f_im(c, pos_exp[c]);
      e.sop = (i == 0);
      e.eop = (i == FFT - 1);
      e.inv = inv;
      sb_q.push_back(e);
      pos_exp[c]++;
    end
    if (n == FFT) tag_q.push_back(c);
  endtask

  // Channel sources: each channel streams f(c, src_pos) and advances on handshake.
  initial begin
    logic [NUM_CH-1:0] acc;
    foreach (src_pos[c]) src_pos[c] = 0;
    forever begin
      @(negedge clk);
      acc = ch_valid & ch_ready;
      @(posedge clk);
      #2;
      for (int c = 0; c < NUM_CH; c++) begin
        if (rst) src_pos[c] = 0;
        else if (acc[c]) src_pos[c]++;
        ch_valid[c] = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        ch_real[c*DW +: DW] = f_re(c, src_pos[c]);
        ch_imag[c*DW +: DW] = f_im(c, src_pos[c]);
      end
      fft_sink_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compares every accepted FFT sample and every output-frame tag.
  always @(negedge clk) begin
    smp_t e;
    int   et;
    if (!rst) begin
      if (fft_sink_valid) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 64'(sb_q.size()), 64'd1);
        end else begin
          e = sb_q.pop_front();
          chk("sample", 64'({fft_sink_real, fft_sink_imag, fft_sink_sop, fft_sink_eop, fft_inverse}),
              64'(e));
        end
        if (fft_sink_sop && gap_chk && last_eop >= 0) chk("eop_sop_gap", 64'(cyc - last_eop), 64'd2);
        if (fft_sink_eop) last_eop = cyc;
      end
      if (fft_source_valid && fft_source_sop) begin
        et = (tag_q.size() != 0) ? tag_q[0] : 0;
        chk("dout_ch", 64'(dout_ch), 64'(et));
      end
      if (fft_source_valid && fft_source_eop && dout_ready && tag_q.size() != 0) void'(tag_q.pop_front());
    end
  end

  task automatic wait_busy(input string name);
    int k = 0;
    while (!busy && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(name, 64'(busy), 64'd1);
  endtask

  task automatic wait_sb(input string name, input int budget);
    int k = 0;
    while (sb_q.size() != 0 && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(name, 64'(sb_q.size()), 64'd0);
  endtask

  task automatic out_frame();
    @(posedge clk); #1;
    fft_source_valid = 1'b1; fft_source_sop = 1'b1; fft_source_eop = 1'b0; dout_ready = 1'b1;
    @(posedge clk); #1;
    fft_source_sop = 1'b0; fft_source_eop = 1'b1;
    @(posedge clk); #1;
    fft_source_valid = 1'b0; fft_source_eop = 1'b0; dout_ready = 1'b0;
  endtask

  task automatic clear_model();
    sb_q.delete();
    tag_q.delete();
    foreach (pos_exp[c]) pos_exp[c] = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    clear_model();
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ch_ready"}, 64'(ch_ready), 64'd0);
    chk({tag, "_sink_valid"}, 64'(fft_sink_valid), 64'd0);
    chk({tag, "_sink_sop_eop"}, 64'({fft_sink_sop, fft_sink_eop}), 64'd0);
    chk({tag, "_sink_data"}, 64'({fft_sink_real, fft_sink_imag}), 64'd0);
    chk({tag, "_inverse"}, 64'(fft_inverse), 64'd0);
    chk({tag, "_dout_ch"}, 64'(dout_ch), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_tag_err"}, 64'(tag_err), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    cp_len = '0; inverse_cfg = '0; ch_req = '0; ch_valid = '0;
    ch_real = '0; ch_imag = '0; fft_sink_ready = 1'b0;
    fft_source_valid = 1'b0; fft_source_sop = 1'b0; fft_source_eop = 1'b0; dout_ready = 1'b0;
    foreach (pos_exp[c]) pos_exp[c] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst0");
    @(posedge clk); #1;
    rst = 1'b0;

    // single channel, 72-sample CP
    cp_len = 10'd72; inverse_cfg = 2'b00;
    push_frame(0, 72, 1'b0, FFT);
    ch_req = 2'b01;
    wait_busy("t1_grant");
    ch_req = 2'b00;
    wait_sb("t1_frame_done", 3000);
    out_frame();

    // both channels, cp 0: alternating grants, 1-cycle gap, FIFO fills
    do_reset();
    cp_len = 10'd0; inverse_cfg = 2'b10;
    push_frame(0, 0, 1'b0, FFT);
    push_frame(1, 0, 1'b1, FFT);
    push_frame(0, 0, 1'b0, FFT);
    push_frame(1, 0, 1'b1, FFT);
    last_eop = -1; gap_chk = 1;
    ch_req = 2'b11;
    wait_busy("t2_grant");
    repeat (100) @(posedge clk);
    #1 inverse_cfg = 2'b01;
    repeat (200) @(posedge clk);
    #1 inverse_cfg = 2'b10;
    wait_sb("t2_four_frames", 6000);
    gap_chk = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("t2_stall_busy", 64'(busy), 64'd0);
      chk("t2_stall_ready", 64'(ch_ready), 64'd0);
    end
    push_frame(0, 0, 1'b0, FFT);
    out_frame();
    wait_busy("t2_resume");
    ch_req = 2'b00;
    wait_sb("t2_frame5", 3000);
    repeat (4) out_frame();

    // random back-pressure and valid gaps; cp_len frozen per grant
    rnd_mode = 1;
    cp_len = 10'd5;
    push_frame(0, 5, 1'b0, FFT);
    ch_req = 2'b01;
    wait_busy("t3_grant0");
    ch_req = 2'b00;
    cp_len = 10'd9;
    wait_sb("t3_frame0", 8000);
    out_frame();
    push_frame(1, 9, 1'b1, FFT);
    ch_req = 2'b10;
    wait_busy("t3_grant1");
    ch_req = 2'b00;
    wait_sb("t3_frame1", 8000);
    rnd_mode = 0;

    // reset in the middle of a frame, with a tag still queued
    cp_len = 10'd0;
    push_frame(0, 0, 1'b0, 500);
    ch_req = 2'b01;
    wait_busy("t4_grant");
    wait_sb("t4_partial", 2000);
    chk("t4_head_before_rst", 64'(dout_ch), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    clear_model();
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("t4_rst");
    push_frame(0, 0, 1'b0, FFT);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_busy("t4_regrant");
    ch_req = 2'b00;
    wait_sb("t4_frame", 3000);
    out_frame();
    @(negedge clk);
    chk("t4_tag_err_clear", 64'(tag_err), 64'd0);
    out_frame();
    @(negedge clk);
    chk("t4_tag_err_set", 64'(tag_err), 64'd1);
    repeat (20) @(negedge clk);
    chk("t4_tag_err_sticky", 64'(tag_err), 64'd1);
    do_reset();
    @(negedge clk);
    chk("t4_tag_err_rst", 64'(tag_err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
